// File: rtl/datapath_pkg.sv
// Shared constants for the Mini-SRC datapath: ALU opcodes, IR field positions and RAM geometry.
package datapath_pkg;

    localparam int DATA_W = 32;

    localparam int RAM_DEPTH = 512;
    localparam int RAM_AW    = 9;

    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;
    localparam int IR_C_MSB  = 18;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A is the Y register, B is the bus; 64-bit result, upper half used only by mul/div.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [4:0]        i_opcode,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [63:0]       o_result
);

    logic [4:0]         w_sh;
    logic [63:0]        w_dbl;
    logic [31:0]        w_ror;
    logic [31:0]        w_rol;
    logic signed [63:0] w_a_sx;
    logic signed [63:0] w_b_sx;
    logic signed [63:0] w_prod;
    logic signed [31:0] w_quo;
    logic signed [31:0] w_rem;
    logic               w_div_ovf;

    assign w_sh   = i_b[4:0];
    assign w_dbl  = {i_a, i_a};
    // Rotates fall out of shifting the operand concatenated with itself.
    assign w_ror  = 32'(w_dbl >> w_sh);
    assign w_rol  = 32'((w_dbl << w_sh) >> 32);
    assign w_a_sx = {{32{i_a[31]}}, i_a};
    assign w_b_sx = {{32{i_b[31]}}, i_b};
    assign w_prod = w_a_sx * w_b_sx;
    assign w_quo  = $signed(i_a) / $signed(i_b);
    assign w_rem  = $signed(i_a) % $signed(i_b);
    assign w_div_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    always_comb begin
        o_result = '0;
        case (i_opcode)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: o_result = {32'd0, i_a + i_b};
            OP_SUB:          o_result = {32'd0, i_a - i_b};
            OP_AND, OP_ANDI: o_result = {32'd0, i_a & i_b};
            OP_OR, OP_ORI:   o_result = {32'd0, i_a | i_b};
            OP_SHR:          o_result = {32'd0, i_a >> w_sh};
            OP_SHRA:         o_result = {32'd0, $unsigned($signed(i_a) >>> w_sh)};
            OP_SHL:          o_result = {32'd0, i_a << w_sh};
            OP_ROR:          o_result = {32'd0, w_ror};
            OP_ROL:          o_result = {32'd0, w_rol};
            OP_MUL:          o_result = $unsigned(w_prod);
            OP_DIV: begin
                if (i_b == '0) begin
                    o_result = {i_a, 32'hFFFF_FFFF};
                end else if (w_div_ovf) begin
                    o_result = {32'd0, i_a};
                end else begin
                    o_result = {$unsigned(w_rem), $unsigned(w_quo)};
                end
            end
            OP_NEG:          o_result = {32'd0, 32'd0 - i_b};
            OP_NOT:          o_result = {32'd0, ~i_b};
            default:         o_result = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-bus Mini-SRC datapath: priority bus mux, register file, PC/IR/MAR/MDR/Y/Z/HI/LO and 512-word RAM.
// All state loads on the rising edge after its enable; clear wins over every load and RAM write.
module datapath
    import datapath_pkg::*;
(
    input  logic              Clock,
    input  logic              clear,
    input  logic              PCout,
    input  logic              Zlowout,
    input  logic              Zhighout,
    input  logic              MDRout,
    input  logic              R2out,
    input  logic              R3out,
    input  logic              InportOut,
    input  logic              Cout,
    input  logic              Rout,
    input  logic              BAout,
    input  logic              GRA,
    input  logic              GRB,
    input  logic              GRC,
    input  logic              Rin,
    input  logic              R1in,
    input  logic              R2in,
    input  logic              R3in,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              PCin,
    input  logic              IRin,
    input  logic              Yin,
    input  logic              Zin,
    input  logic              HIin,
    input  logic              LOin,
    input  logic              IncPC,
    input  logic              Read,
    input  logic              Write,
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic [DATA_W-1:0] InportIn
);

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] y;
    logic [63:0]       z;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] inport_q;
    logic [DATA_W-1:0] r   [0:15];
    logic [DATA_W-1:0] ram [0:RAM_DEPTH-1];

    logic [3:0]        w_sel_idx;
    logic [DATA_W-1:0] w_c_sext;
    logic [DATA_W-1:0] w_reg_dat;
    logic              w_ram_hit;
    logic [DATA_W-1:0] w_mem_dat;
    logic [63:0]       w_alu_res;
    logic              w_unused;

    assign w_sel_idx = ({4{GRA}} & ir[IR_RA_MSB:IR_RA_LSB])
                     | ({4{GRB}} & ir[IR_RB_MSB:IR_RB_LSB])
                     | ({4{GRC}} & ir[IR_RC_MSB:IR_RC_LSB]);

    assign w_c_sext  = {{(DATA_W-IR_C_MSB-1){ir[IR_C_MSB]}}, ir[IR_C_MSB:0]};

    // BAout gives base-address semantics: R0 as a base reads as zero.
    assign w_reg_dat = (BAout && (w_sel_idx == 4'd0)) ? '0 : r[w_sel_idx];

    assign w_ram_hit = (mar[DATA_W-1:RAM_AW] == '0);
    assign w_mem_dat = w_ram_hit ? ram[mar[RAM_AW-1:0]] : Mdatain;

    assign w_unused  = ^ir[DATA_W-1:IR_RA_MSB+1];

    always_comb begin
        bus = '0;
        if (InportOut)          bus = inport_q;
        else if (Cout)          bus = w_c_sext;
        else if (Rout || BAout) bus = w_reg_dat;
        else if (MDRout)        bus = mdr;
        else if (Zhighout)      bus = z[63:32];
        else if (Zlowout)       bus = z[31:0];
        else if (PCout)         bus = pc;
        else if (R2out)         bus = r[2];
        else if (R3out)         bus = r[3];
    end

    datapath_alu u_alu (
        .i_opcode (opcode),
        .i_a      (y),
        .i_b      (bus),
        .o_result (w_alu_res)
    );

    always_ff @(posedge Clock) begin
        if (clear) begin
            pc       <= '0;
            ir       <= '0;
            mar      <= '0;
            mdr      <= '0;
            y        <= '0;
            z        <= '0;
            hi       <= '0;
            lo       <= '0;
            inport_q <= '0;
        end else begin
            inport_q <= InportIn;
            if (PCin)  pc  <= IncPC ? pc + 32'd1 : bus;
            if (IRin)  ir  <= bus;
            if (MARin) mar <= bus;
            if (MDRin) mdr <= Read ? w_mem_dat : bus;
            if (Yin)   y   <= bus;
            if (Zin)   z   <= w_alu_res;
            if (HIin)  hi  <= bus;
            if (LOin)  lo  <= bus;
        end
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                r[i] <= '0;
            end
        end else begin
            if (Rin)  r[w_sel_idx] <= bus;
            if (R1in) r[1] <= bus;
            if (R2in) r[2] <= bus;
            if (R3in) r[3] <= bus;
        end
    end

    // RAM has no reset; only the write is gated by clear.
    always_ff @(posedge Clock) begin
        if (!clear && Write && w_ram_hit) begin
            ram[mar[RAM_AW-1:0]] <= mdr;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed bench acting as the control unit; checks internal state through hierarchical probes.
module tb_datapath;

    logic        Clock = 1'b0;
    logic        clear;
    logic        PCout, Zlowout, Zhighout, MDRout, R2out, R3out, InportOut, Cout;
    logic        Rout, BAout, GRA, GRB, GRC, Rin, R1in, R2in, R3in;
    logic        MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, IncPC, Read, Write;
    logic [4:0]  opcode;
    logic [31:0] Mdatain;
    logic [31:0] InportIn;

    int vectors     = 0;
    int miscompares = 0;

    localparam int D_PC  = 0;
    localparam int D_IR  = 1;
    localparam int D_MAR = 2;
    localparam int D_MDR = 3;
    localparam int D_Y   = 4;
    localparam int D_R1  = 5;
    localparam int D_R2  = 6;
    localparam int D_RA  = 7;
    localparam int D_RC  = 8;
    localparam int D_Z   = 9;

    always #5 Clock = ~Clock;

    datapath dut (
        .Clock(Clock), .clear(clear),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .R2out(R2out), .R3out(R3out), .InportOut(InportOut), .Cout(Cout),
        .Rout(Rout), .BAout(BAout), .GRA(GRA), .GRB(GRB), .GRC(GRC),
        .Rin(Rin), .R1in(R1in), .R2in(R2in), .R3in(R3in),
        .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .opcode(opcode), .Mdatain(Mdatain), .InportIn(InportIn)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        {PCout, Zlowout, Zhighout, MDRout, R2out, R3out, InportOut, Cout} = '0;
        {Rout, BAout, GRA, GRB, GRC, Rin, R1in, R2in, R3in} = '0;
        {MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, IncPC, Read, Write} = '0;
        opcode = 5'b00000;
    endtask

    // Value enters through the in-port register, then is driven onto the bus into dst.
    task automatic ld(input logic [31:0] v, input int dst);
        idle();
        InportIn = v;
        tick();
        InportOut = 1'b1;
        case (dst)
            D_PC:    PCin  = 1'b1;
            D_IR:    IRin  = 1'b1;
            D_MAR:   MARin = 1'b1;
            D_MDR:   MDRin = 1'b1;
            D_Y:     Yin   = 1'b1;
            D_R1:    R1in  = 1'b1;
            D_R2:    R2in  = 1'b1;
            D_RA:    begin GRA = 1'b1; Rin = 1'b1; end
            D_RC:    begin GRC = 1'b1; Rin = 1'b1; end
            default: Zin   = 1'b1;
        endcase
        tick();
        idle();
    endtask

    task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        ld(a, D_Y);
        InportIn = b;
        tick();
        InportOut = 1'b1;
        Zin       = 1'b1;
        opcode    = op;
        tick();
        idle();
    endtask

    initial begin
        idle();
        clear    = 1'b1;
        InportIn = '0;
        Mdatain  = '0;
        tick();
        clear = 1'b0;
        check("rst_pc", dut.pc, 0);
        check("rst_r15", dut.r[15], 0);

        ld(32'h5, D_MAR);
        ld(32'hDEAD_BEEF, D_MDR);
        Write = 1'b1;
        tick();
        idle();
        check("ram5_wr", dut.ram[5], 64'hDEAD_BEEF);
        ld(32'h1234, D_PC);
        ld(32'h77, D_R1);
        ld(32'h3, D_Y);
        ld(32'h4, D_Z);
        check("pre_clr_z", dut.z, 64'h7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_pc", dut.pc, 0);
        check("clr_z", dut.z, 0);
        check("clr_r1", dut.r[1], 0);
        check("clr_mdr", dut.mdr, 0);
        check("clr_y", dut.y, 0);
        check("clr_ram5", dut.ram[5], 64'hDEAD_BEEF);

        ld(32'h33, D_PC);
        InportIn  = 32'h11;
        InportOut = 1'b1;
        MDRin     = 1'b1;
        PCout     = 1'b1;
        tick();
        check("inport_mdr_e1", dut.mdr, 64'h33);
        tick();
        check("inport_bus_prio", dut.bus, 64'h11);
        check("inport_mdr_e2", dut.mdr, 64'h11);
        idle();
        #1;
        check("bus_idle", dut.bus, 0);
        ld(32'hA2, D_R2);
        R2out = 1'b1;
        R3out = 1'b1;
        #1;
        check("bus_r2", dut.bus, 64'hA2);
        PCout = 1'b1;
        #1;
        check("bus_pc_over_r2", dut.bus, 64'h33);
        idle();

        ld(32'h47, D_R1);
        ld(32'h0088_0005, D_IR);
        GRB = 1'b1; BAout = 1'b1; Yin = 1'b1;
        tick();
        idle();
        check("ba_r1_y", dut.y, 64'h47);
        Cout = 1'b1; Zin = 1'b1; opcode = 5'b00000;
        tick();
        idle();
        check("addi_z", dut.z, 64'h4C);
        ld(32'h0000_0005, D_IR);
        ld(32'h99, D_RA);
        check("rin_r0", dut.r[0], 64'h99);
        GRB = 1'b1; BAout = 1'b1; Yin = 1'b1;
        tick();
        idle();
        check("ba_r0_y", dut.y, 0);
        Cout = 1'b1; Zin = 1'b1;
        tick();
        idle();
        check("addi_r0_z", dut.z, 64'h5);
        GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
        tick();
        idle();
        check("rout_r0_y", dut.y, 64'h99);
        ld(32'h0001_8000, D_IR);
        ld(32'h5A, D_RC);
        check("rin_rc_r3", dut.r[3], 64'h5A);
        ld(32'h0004_0000, D_IR);
        Cout = 1'b1; Yin = 1'b1;
        tick();
        idle();
        check("c_sext", dut.y, 64'hFFFC_0000);

        ld(32'h0, D_MAR);
        ld(32'h12, D_MDR);
        Write = 1'b1;
        tick();
        idle();
        ld(32'h4C, D_MAR);
        ld(32'h87, D_MDR);
        Write = 1'b1;
        tick();
        idle();
        check("ram_wr_4c", dut.ram[76], 64'h87);
        ld(32'h0, D_MDR);
        Read = 1'b1; MDRin = 1'b1;
        tick();
        idle();
        check("ram_rd_4c", dut.mdr, 64'h87);
        ld(32'h1000, D_MAR);
        Mdatain = 32'hCAFE_F00D;
        Read = 1'b1; MDRin = 1'b1;
        tick();
        idle();
        check("ext_rd", dut.mdr, 64'hCAFE_F00D);
        Write = 1'b1;
        tick();
        idle();
        check("ext_wr_dropped", dut.ram[0], 64'h12);
        ld(32'h4C, D_MAR);
        ld(32'h55, D_MDR);
        Write = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle();
        check("clr_wr_suppr", dut.ram[76], 64'h87);
        check("clr_mar", dut.mar, 0);

        alu_op(32'hFFFF_FFFE, 32'h3, 5'b01111);
        check("mul", dut.z, 64'hFFFF_FFFF_FFFF_FFFA);
        Zhighout = 1'b1; HIin = 1'b1;
        tick();
        idle();
        check("hi", dut.hi, 64'hFFFF_FFFF);
        Zlowout = 1'b1; LOin = 1'b1;
        tick();
        idle();
        check("lo", dut.lo, 64'hFFFF_FFFA);
        alu_op(32'h7, 32'h2, 5'b10000);
        check("div", dut.z, 64'h0000_0001_0000_0003);
        alu_op(32'h7, 32'h0, 5'b10000);
        check("div0", dut.z, 64'h0000_0007_FFFF_FFFF);
        alu_op(32'h7, 32'h2, 5'b00100);
        check("sub", dut.z, 64'h5);
        alu_op(32'hFFFF_FFFF, 32'h1, 5'b00011);
        check("add_wrap", dut.z, 64'h0);
        alu_op(32'hF0F0_1234, 32'h0FF0_00FF, 5'b00101);
        check("and", dut.z, 64'h00F0_0034);
        alu_op(32'hF000_0000, 32'h0000_000F, 5'b01110);
        check("ori", dut.z, 64'hF000_000F);
        alu_op(32'h8000_0000, 32'h4, 5'b00111);
        check("shr", dut.z, 64'h0800_0000);
        alu_op(32'h8000_0000, 32'h4, 5'b01000);
        check("shra", dut.z, 64'hF800_0000);
        alu_op(32'h3, 32'h1F, 5'b01001);
        check("shl", dut.z, 64'h8000_0000);
        alu_op(32'h1, 32'h1, 5'b01010);
        check("ror", dut.z, 64'h8000_0000);
        alu_op(32'h8000_0001, 32'h4, 5'b01011);
        check("rol", dut.z, 64'h18);
        alu_op(32'h0, 32'h2, 5'b10001);
        check("neg", dut.z, 64'hFFFF_FFFE);
        alu_op(32'h0, 32'h0F0F_0F0F, 5'b10010);
        check("not", dut.z, 64'hF0F0_F0F0);
        alu_op(32'h5, 32'h6, 5'b10011);
        check("illegal_op", dut.z, 64'h0);

        ld(32'h7, D_Y);
        InportIn = 32'h5;
        tick();
        InportOut = 1'b1; Yin = 1'b1; Zin = 1'b1; opcode = 5'b00000;
        tick();
        idle();
        check("zy_old_y", dut.z, 64'hC);
        check("zy_new_y", dut.y, 64'h5);

        ld(32'h10, D_PC);
        PCin = 1'b1; IncPC = 1'b1;
        tick();
        idle();
        check("pc_inc", dut.pc, 64'h11);
        ld(32'h40, D_MDR);
        MDRout = 1'b1; PCin = 1'b1;
        tick();
        idle();
        check("pc_bus", dut.pc, 64'h40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
